// File: rtl/dm_uart_transmitter.sv
// Streams NUM_BYTES bytes from data memory, starting at BASE_ADDR, out over an 8N1 UART line.
// Define PARITY_EN to add an even-parity bit between the data bits and the stop bit (8E1).
module dm_uart_transmitter #(
    parameter logic [15:0] CLKS_PER_BIT = 16'd434,
    parameter logic [15:0] BASE_ADDR    = 16'd0,
    parameter logic [15:0] NUM_BYTES    = 16'd1024
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        begin_transmit,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        data_to_pc,
    output logic        busy,
    output logic        end_transmitting
);

`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP, DONE} state_t;
`endif

    localparam logic [15:0] LAST_CNT = CLKS_PER_BIT - 16'd1;

    state_t      state_reg, state_next;
    logic [15:0] bit_cnt_reg, bit_cnt_next;
    logic [3:0]  bit_idx_reg, bit_idx_next;
    logic [15:0] byte_cnt_reg, byte_cnt_next;
    logic [7:0]  shreg_reg, shreg_next;
    logic [15:0] mem_addr_reg, mem_addr_next;
    logic        line_reg, line_next;
    logic        busy_reg, end_reg;
    logic        bit_last;

    assign bit_last         = (bit_cnt_reg == LAST_CNT);
    assign mem_addr         = mem_addr_reg;
    assign data_to_pc       = line_reg;
    assign busy             = busy_reg;
    assign end_transmitting = end_reg;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            byte_cnt_reg <= '0;
            shreg_reg    <= '0;
            mem_addr_reg <= BASE_ADDR;
            line_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            end_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            byte_cnt_reg <= byte_cnt_next;
            shreg_reg    <= shreg_next;
            mem_addr_reg <= mem_addr_next;
            line_reg     <= line_next;
            busy_reg     <= (state_next != IDLE) && (state_next != DONE);
            end_reg      <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        byte_cnt_next = byte_cnt_reg;
        shreg_next    = shreg_reg;
        mem_addr_next = mem_addr_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (begin_transmit) begin
                    mem_addr_next = BASE_ADDR;
                    byte_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = (NUM_BYTES == 16'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                // Address was presented on entry; RAM q is valid on the second edge.
                if (bit_cnt_reg == 16'd1) begin
                    shreg_next   = mem_data;
                    bit_cnt_next = '0;
                    state_next   = START;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 16'd1;
                end
            end
            START: begin
                if (bit_last) begin
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 16'd1;
                end
            end
            DATA: begin
                if (bit_last) begin
                    bit_cnt_next = '0;
                    if (bit_idx_reg == 4'd7) begin
`ifdef PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 4'd1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 16'd1;
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (bit_last) begin
                    bit_cnt_next = '0;
                    state_next   = STOP;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_last) begin
                    bit_cnt_next  = '0;
                    byte_cnt_next = byte_cnt_reg + 16'd1;
                    if (byte_cnt_reg + 16'd1 == NUM_BYTES) begin
                        state_next = DONE;
                    end else begin
                        mem_addr_next = mem_addr_reg + 16'd1;
                        state_next    = FETCH;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level is derived from the next state so the registered output lines up with it.
    always_comb begin
        line_next = 1'b1;
        case (state_next)
            START:   line_next = 1'b0;
            DATA:    line_next = shreg_next[bit_idx_next[2:0]];
`ifdef PARITY_EN
            PARITY:  line_next = ^shreg_next;
`endif
            default: line_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_dm_uart_transmitter.sv
// Self-checking bench for dm_uart_transmitter: four instances with different BASE_ADDR/NUM_BYTES,
// each with its own 1-cycle-latency sync RAM, checked cycle by cycle against a frame-level model.
module tb_dm_uart_transmitter;

    localparam int CPB = 4;
`ifdef PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif
    localparam int FRAME = FBITS * CPB + 2;

    // Instances: 0 single byte @0x10, 1 three bytes @0x10, 2 wrap @0xFFFF, 3 zero bytes.
    localparam logic [63:0] BASES = {16'h0000, 16'hFFFF, 16'h0010, 16'h0010};
    localparam logic [63:0] NUMS  = {16'd0, 16'd2, 16'd3, 16'd1};

    logic        clock = 1'b0;
    logic [3:0]  rst_r;
    logic [3:0]  begin_r;
    logic [3:0]  line_w, busy_w, end_w;
    logic [15:0] addr_w [4];
    logic [7:0]  ram [4][65536];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            logic [7:0] q_reg;
            always @(posedge clock) q_reg <= ram[gi][addr_w[gi]];

            dm_uart_transmitter #(
                .CLKS_PER_BIT(16'(CPB)),
                .BASE_ADDR   (BASES[gi*16 +: 16]),
                .NUM_BYTES   (NUMS[gi*16 +: 16])
            ) u_dut (
                .clock           (clock),
                .rst             (rst_r[gi]),
                .begin_transmit  (begin_r[gi]),
                .mem_addr        (addr_w[gi]),
                .mem_data        (q_reg),
                .data_to_pc      (line_w[gi]),
                .busy            (busy_w[gi]),
                .end_transmitting(end_w[gi])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level p cycles into a byte slot: 2 fetch cycles high, start, 8 data LSB first,
    // optional even parity, stop.
    function automatic logic exp_line(input logic [7:0] b, input int p);
        int q;
        if (p < 2) return 1'b1;
        q = (p - 2) / CPB;
        if (q == 0) return 1'b0;
        if (q <= 8) return b[q-1];
`ifdef PARITY_EN
        if (q == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // One full transfer on instance k; optional begin_transmit pulse in the middle of byte 0 DATA.
    task automatic transfer(input int k, input bit poke);
        logic [15:0] base, ea;
        logic [7:0]  b;
        int n, total;
        base  = BASES[k*16 +: 16];
        n     = int'(NUMS[k*16 +: 16]);
        total = n * FRAME;
        begin_r[k] = 1'b1;
        @(negedge clock);
        begin_r[k] = 1'b0;
        for (int t = 0; t < total; t++) begin
            ea = base + 16'(t / FRAME);
            b  = ram[k][ea];
            chk($sformatf("i%0d_t%0d_line_busy_end", k, t),
                {29'd0, line_w[k], busy_w[k], end_w[k]},
                {29'd0, exp_line(b, t % FRAME), 1'b1, 1'b0});
            if (t % FRAME == 0)
                chk($sformatf("i%0d_t%0d_addr", k, t), {16'd0, addr_w[k]}, {16'd0, ea});
            if (poke) begin_r[k] = (t == 2 + CPB + 5);
            @(negedge clock);
        end
        begin_r[k] = 1'b0;
        ea = (n == 0) ? base : base + 16'(n - 1);
        chk($sformatf("i%0d_done_end_busy_line", k), {29'd0, end_w[k], busy_w[k], line_w[k]}, 32'b101);
        chk($sformatf("i%0d_done_addr", k), {16'd0, addr_w[k]}, {16'd0, ea});
        $display("transfer inst=%0d bytes=%0d base=%04h cycles=%0d poke=%0d", k, n, base, total, poke);
    endtask

    task automatic reset_mid(input int k);
        int stop_t;
        stop_t = 2 + CPB + 3 * CPB + 1;   // inside data bit 3 of byte 0
        begin_r[k] = 1'b1;
        @(negedge clock);
        begin_r[k] = 1'b0;
        repeat (stop_t) @(negedge clock);
        rst_r[k] = 1'b1;
        @(negedge clock);
        rst_r[k] = 1'b0;
        chk($sformatf("i%0d_rstmid_line_busy_end", k), {29'd0, line_w[k], busy_w[k], end_w[k]}, 32'b100);
        chk($sformatf("i%0d_rstmid_addr", k), {16'd0, addr_w[k]}, {16'd0, BASES[k*16 +: 16]});
        for (int t = 0; t < 30; t++) begin
            @(negedge clock);
            chk($sformatf("i%0d_rstmid_idle_t%0d", k, t), {29'd0, line_w[k], busy_w[k], end_w[k]}, 32'b100);
        end
        $display("reset mid-frame inst=%0d at cycle %0d after accept", k, stop_t);
    endtask

    initial begin
        rst_r   = 4'hF;
        begin_r = 4'h0;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("i%0d_reset_line_busy_end", k), {29'd0, line_w[k], busy_w[k], end_w[k]}, 32'b100);
            chk($sformatf("i%0d_reset_addr", k), {16'd0, addr_w[k]}, {16'd0, BASES[k*16 +: 16]});
        end
        rst_r = 4'h0;
        @(negedge clock);
        $display("reset released");

        // Single byte 0x55.
        ram[0][16'h0010] = 8'h55;
        transfer(0, 1'b0);

        // Three bytes with an ignored begin_transmit pulse during DATA.
        ram[1][16'h0010] = 8'hA3;
        ram[1][16'h0011] = 8'h00;
        ram[1][16'h0012] = 8'hFF;
        transfer(1, 1'b1);

        // Address wrap 0xFFFF -> 0x0000.
        ram[2][16'hFFFF] = 8'($urandom);
        ram[2][16'h0000] = 8'($urandom);
        transfer(2, 1'b0);

        // NUM_BYTES = 0: immediate DONE, line never low.
        transfer(3, 1'b0);
        for (int t = 0; t < 6; t++) begin
            @(negedge clock);
            chk($sformatf("i3_zero_hold_t%0d", t), {30'd0, line_w[3], end_w[3]}, 32'b11);
        end

        // Restart from DONE; byte 0x07 exercises parity when enabled.
        ram[0][16'h0010] = 8'h07;
        transfer(0, 1'b0);

        // Reset during data bit 3 of an all-zero byte.
        ram[1][16'h0010] = 8'h00;
        reset_mid(1);

        // Randomised payloads and begin_transmit pokes.
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 3; a++) ram[1][16'h0010 + 16'(a)] = 8'($urandom);
            transfer(1, 1'($urandom_range(0, 1)));
            ram[2][16'hFFFF] = 8'($urandom);
            ram[2][16'h0000] = 8'($urandom);
            transfer(2, 1'b0);
            ram[0][16'h0010] = 8'($urandom);
            transfer(0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
